par_serial_lane: RTL and testbench
==================================

// Module: par_serial_lane
// PURPOSE
//  Per-lane parallel-to-serial transmitter. Sits directly downstream of the lane
//  byte source (data_in_*_c / valid_in_*_c) and drives one serial bit per clk_8f.
//  After reset it sends a training run of COM symbols, then sends data bytes when
//  valid and IDLE symbols when not. Two instances (lane 0, lane 1) feed the link.
// PARAMETERS
//  COM_SYM   8'hBC  training/comma symbol sent after reset
//  IDLE_SYM  8'h7C  filler symbol sent when no valid byte is offered
//  NUM_COM   4      COM symbols sent before entering ACTIVE (1..15)
// PORTS
//  clk_8f      in   1  bit clock; all logic on posedge
//  reset       in   1  synchronous, active-high reset
//  data_in     in   8  byte offered by upstream
//  valid_in    in   1  data_in holds a real byte
//  data_ready  out  1  this cycle is a symbol load cycle in ACTIVE; byte accepted if valid_in
//  serial_out  out  1  registered serial bit, MSB first
//  sym_start   out  1  registered; high while serial_out carries bit 7 of a symbol
//  sync_done   out  1  registered; high in ACTIVE
// BEHAVIOUR
//  - Reset (reset=1 at posedge): state<=SYNC, bit_cnt<=0, com_cnt<=0, shift<=0,
//    serial_out<=0, sym_start<=0, sync_done<=0. data_ready forced 0 while reset=1.
//  - bit_cnt: 3-bit, increments every non-reset cycle, wraps 7->0. bit_cnt==0 is the
//    load cycle; one symbol every 8 clocks, no gaps.
//  - Load cycle symbol select: SYNC -> COM_SYM; ACTIVE & valid_in -> data_in;
//    ACTIVE & !valid_in -> IDLE_SYM. Symbol latched into shift; serial_out<=sym[7],
//    sym_start<=1 at that edge (data_in bit 7 visible 1 clock after its load edge).
//  - Non-load cycles: serial_out<=shift[7-bit_cnt], sym_start<=0. data_in ignored.
//  - data_ready = (state==ACTIVE) & (bit_cnt==0) & !reset, combinational. Transfer
//    occurs on posedge where data_ready & valid_in. Upstream holds data_in/valid_in
//    until a transfer; valid_in may drop without a transfer (no byte lost: IDLE sent).
//  - FSM: SYNC: on each load cycle com_cnt++; when load of COM number NUM_COM occurs,
//    state<=ACTIVE at the end of that symbol (edge where bit_cnt 7->0) so the first
//    ACTIVE load is the symbol immediately following the last COM. ACTIVE: stays
//    until reset. sync_done<=1 on the same edge state enters ACTIVE.
//  - Reset mid-symbol: symbol abandoned, partial bits not completed; first symbol
//    after release is COM with bit_cnt=0 on the first non-reset edge.
//  - valid_in and data_in during SYNC: ignored, never consumed (data_ready=0).
//  - Exactly 8*NUM_COM COM bits precede the first data/IDLE bit.
// STRUCTURE
//  - Shared package/include (pcie_defs): COM_SYM/IDLE_SYM defaults, state encoding
//    localparams ST_SYNC=1'b0, ST_ACTIVE=1'b1, symbol width 8.
//  - One natural sub-module: sym_shift8 (8-bit load/shift register + bit_cnt,
//    outputs serial_out, sym_start, load strobe). FSM and symbol mux stay in top.
// TESTING
//  - Reset 3 cycles, release, valid_in=0 -> serial_out shows 0xBC x4 (10111100 each),
//    then 0x7C repeating; sync_done rises on edge 32 after release; sym_start every 8.
//  - After sync, data_in=0xA4 valid_in=1 held until data_ready -> next symbol on line
//    is 10100100, data_ready high exactly 1 cycle per 8.
//  - Back-to-back bytes 0xFF,0xEE,0xDD,0xCC each presented on transfer -> 32 contiguous
//    bits FF EE DD CC, no IDLE between them.
//  - valid_in toggled on non-load cycles (data_in=0x32) -> no effect; only load-cycle
//    value matters; 0x7C sent if valid_in=0 at load edge.
//  - reset asserted at bit_cnt=3 of byte 0x88 -> serial_out=0 next edge; after release
//    4 COM symbols again, sync_done=0 until resync completes.
//  - valid_in=1 data_in=0x55 during SYNC -> never appears; first ACTIVE symbol is 0x55.

Source files
------------

// File: rtl/par_serial_lane_pkg.sv
// Shared definitions for the lane serializer: symbol codes, FSM encoding
// and the load-cycle symbol select.
package par_serial_lane_pkg;

   localparam int SYM_W = 8;

   typedef logic [SYM_W-1:0] sym_t;

   localparam sym_t COM_SYM_DEF  = 8'hBC;
   localparam sym_t IDLE_SYM_DEF = 8'h7C;

   localparam logic [0:0] ST_SYNC   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   // Training always wins; once active, a real byte beats the filler.
   function automatic sym_t sel_sym(input logic active, input logic valid,
                                    input sym_t data, input sym_t com_sym,
                                    input sym_t idle_sym);
      sym_t s;
      if (!active)
         s = com_sym;
      else if (valid)
         s = data;
      else
         s = idle_sym;
      return s;
   endfunction

endpackage

// File: rtl/par_serial_lane_shift8.sv
// 8-bit load/shift register with free-running bit counter; one symbol
// every 8 clocks, MSB first, registered serial output.
module sym_shift8
   import par_serial_lane_pkg::*;
(
   input  logic       clk_8f,
   input  logic       reset,
   input  sym_t       sym,
   output logic       serial_out,
   output logic       sym_start,
   output logic       load,
   output logic [2:0] bit_cnt
);

   sym_t shift;

   assign load = (bit_cnt == 3'd0);

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         bit_cnt    <= 3'd0;
         shift      <= '0;
         serial_out <= 1'b0;
         sym_start  <= 1'b0;
      end else begin
         bit_cnt <= bit_cnt + 3'd1;
         if (load) begin
            shift      <= sym;
            serial_out <= sym[7];
            sym_start  <= 1'b1;
         end else begin
            // bit 7 already went out on the load edge
            serial_out <= shift[3'd7 - bit_cnt];
            sym_start  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/par_serial_lane.sv
// Per-lane parallel-to-serial transmitter: COM training run after reset,
// then data bytes or IDLE filler, one bit per clk_8f.
//
// state     | meaning
// ST_SYNC   | sending NUM_COM COM symbols, upstream bytes ignored
// ST_ACTIVE | sending data_in when valid at load, IDLE otherwise
module par_serial_lane
   import par_serial_lane_pkg::*;
#(
   parameter logic [7:0] COM_SYM  = COM_SYM_DEF,
   parameter logic [7:0] IDLE_SYM = IDLE_SYM_DEF,
   parameter int         NUM_COM  = 4
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       data_ready,
   output logic       serial_out,
   output logic       sym_start,
   output logic       sync_done
);

   localparam logic [3:0] NUM_COM_C = 4'(NUM_COM);

   logic [0:0] state;
   logic [3:0] com_cnt;
   logic       load;
   logic [2:0] bit_cnt;
   sym_t       sym;

   assign sym        = sel_sym(state == ST_ACTIVE, valid_in, data_in, COM_SYM, IDLE_SYM);
   assign data_ready = (state == ST_ACTIVE) && load && !reset;

   sym_shift8 u_shift (
      .clk_8f     (clk_8f),
      .reset      (reset),
      .sym        (sym),
      .serial_out (serial_out),
      .sym_start  (sym_start),
      .load       (load),
      .bit_cnt    (bit_cnt)
   );

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         state     <= ST_SYNC;
         com_cnt   <= 4'd0;
         sync_done <= 1'b0;
      end else if (state == ST_SYNC) begin
         if (load)
            com_cnt <= com_cnt + 4'd1;
         // leave SYNC only once the last COM has fully shifted out
         if ((bit_cnt == 3'd7) && (com_cnt == NUM_COM_C)) begin
            state     <= ST_ACTIVE;
            sync_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_par_serial_lane.sv
// Directed bench for par_serial_lane: training run, data/IDLE selection,
// back-to-back bytes, valid toggling, mid-symbol reset and resync.
module tb_par_serial_lane;

   logic       clk_8f = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       data_ready;
   logic       serial_out;
   logic       sym_start;
   logic       sync_done;

   int n_tests = 0;
   int n_fail  = 0;

   par_serial_lane dut (
      .clk_8f     (clk_8f),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .data_ready (data_ready),
      .serial_out (serial_out),
      .sym_start  (sym_start),
      .sync_done  (sync_done)
   );

   always #5 clk_8f = ~clk_8f;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_8f);
      #1;
   endtask

   // Collect one 8-bit symbol starting at a load edge. After the load edge,
   // nv/nd become the upstream offer for the following load; with tog set,
   // valid_in flips on non-load cycles before settling back to nv.
   task automatic get_sym(input logic nv, input logic [7:0] nd, input logic tog,
                          output logic [7:0] b, output int dr_cnt);
      b = 8'h00;
      dr_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         b = {b[6:0], serial_out};
         chk($sformatf("sym_start_bit%0d", i), {7'd0, sym_start}, {7'd0, (i == 0)});
         if (i < 7) dr_cnt += int'(data_ready);
         if (i == 0) begin
            valid_in = nv;
            data_in  = nd;
         end else if (tog && i <= 5) begin
            valid_in = ~valid_in;
         end else if (i == 6) begin
            valid_in = nv;
         end
      end
   endtask

   initial begin
      logic [7:0] s;
      int         dr;

      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = 8'h00;
      tick(); tick(); tick();
      chk("rst_serial", {7'd0, serial_out}, 8'h00);
      chk("rst_sym_start", {7'd0, sym_start}, 8'h00);
      chk("rst_sync_done", {7'd0, sync_done}, 8'h00);
      chk("rst_data_ready", {7'd0, data_ready}, 8'h00);
      reset = 1'b0;

      // training run: four COM symbols, sync_done only after the fourth
      for (int k = 1; k <= 4; k++) begin
         get_sym(1'b0, 8'h00, 1'b0, s, dr);
         chk($sformatf("com%0d", k), s, 8'hBC);
         chk($sformatf("com%0d_ready_mid", k), 8'(dr), 8'h00);
         chk($sformatf("com%0d_sync_done", k), {7'd0, sync_done}, {7'd0, (k == 4)});
         chk($sformatf("com%0d_ready_end", k), {7'd0, data_ready}, {7'd0, (k == 4)});
      end

      // first active symbol with nothing offered is IDLE; offer 0xA4 meanwhile
      get_sym(1'b1, 8'hA4, 1'b0, s, dr);
      chk("idle_after_sync", s, 8'h7C);
      chk("idle_ready_mid", 8'(dr), 8'h00);
      chk("a4_ready_at_load", {7'd0, data_ready}, 8'h01);

      get_sym(1'b1, 8'hFF, 1'b0, s, dr);
      chk("byte_a4", s, 8'hA4);
      chk("a4_ready_once", 8'(dr), 8'h00);
      get_sym(1'b1, 8'hEE, 1'b0, s, dr);
      chk("b2b_ff", s, 8'hFF);
      get_sym(1'b1, 8'hDD, 1'b0, s, dr);
      chk("b2b_ee", s, 8'hEE);
      get_sym(1'b1, 8'hCC, 1'b0, s, dr);
      chk("b2b_dd", s, 8'hDD);
      get_sym(1'b0, 8'h32, 1'b1, s, dr);
      chk("b2b_cc", s, 8'hCC);

      // valid_in wiggled mid-symbol but low at the load edge
      get_sym(1'b1, 8'h88, 1'b0, s, dr);
      chk("toggle_idle", s, 8'h7C);
      chk("toggle_ready_mid", 8'(dr), 8'h00);

      // 0x88 starts, reset lands with bit_cnt=3
      tick();
      chk("b88_bit7", {7'd0, serial_out}, 8'h01);
      tick();
      chk("b88_bit6", {7'd0, serial_out}, 8'h00);
      tick();
      chk("b88_bit5", {7'd0, serial_out}, 8'h00);
      reset = 1'b1;
      chk("ready_low_in_reset", {7'd0, data_ready}, 8'h00);
      tick();
      chk("midrst_serial", {7'd0, serial_out}, 8'h00);
      chk("midrst_sym_start", {7'd0, sym_start}, 8'h00);
      chk("midrst_sync_done", {7'd0, sync_done}, 8'h00);
      valid_in = 1'b1;
      data_in  = 8'h55;
      tick();
      reset = 1'b0;
      chk("resync_ready_load1", {7'd0, data_ready}, 8'h00);

      // 0x55 offered throughout SYNC must not be consumed until active
      for (int k = 1; k <= 4; k++) begin
         get_sym(1'b1, 8'h55, 1'b0, s, dr);
         chk($sformatf("recom%0d", k), s, 8'hBC);
         chk($sformatf("recom%0d_sync_done", k), {7'd0, sync_done}, {7'd0, (k == 4)});
         chk($sformatf("recom%0d_ready_end", k), {7'd0, data_ready}, {7'd0, (k == 4)});
      end
      get_sym(1'b0, 8'h00, 1'b0, s, dr);
      chk("first_active_55", s, 8'h55);
      chk("post55_ready", {7'd0, data_ready}, 8'h01);

      // combinational gating by reset on an active load cycle
      reset = 1'b1;
      #1;
      chk("ready_gated_by_reset", {7'd0, data_ready}, 8'h00);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
